// File: rtl/trng_pkg.sv
// Shared types and default parameters for the TRNG conditioning path.
// Health testing is enabled by defining TRNG_HEALTH_EN when building trng_byte_packer.
package trng_pkg;

    typedef enum logic {
        EMPTY      = 1'b0,
        HAVE_FIRST = 1'b1
    } pair_state_t;

    localparam int TRNG_WORD_W    = 8;
    localparam int TRNG_RCT_LIMIT = 32;

    // Advances a counter by one but holds it once it reaches the limit.
    function automatic int unsigned sat_inc(input int unsigned value, input int unsigned limit);
        return (value >= limit) ? limit : value + 1;
    endfunction

endpackage

// File: rtl/trng_von_neumann.sv
// Von Neumann debiaser: turns raw sample pairs 10/01 into a single bit and drops 00/11.
// vn_bit/vn_valid are combinational, so an accepted bit is seen in the sample's own cycle.
module trng_von_neumann
    import trng_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic raw_bit,
    input  logic raw_valid,
    input  logic debias_bypass,
    output logic vn_bit,
    output logic vn_valid
);

    pair_state_t state;
    logic        first_bit;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            first_bit <= 1'b0;
        end else if (debias_bypass) begin
            // Entering bypass drops any half pair, so leaving it never emits a stale bit.
            state <= EMPTY;
        end else if (raw_valid) begin
            case (state)
                EMPTY: begin
                    first_bit <= raw_bit;
                    state     <= HAVE_FIRST;
                end
                HAVE_FIRST: state <= EMPTY;
                default:    state <= EMPTY;
            endcase
        end
    end

    // NOTE: every output gets a default first so this block can never infer a latch.
    always_comb begin
        vn_valid = 1'b0;
        vn_bit   = raw_bit;
        if (raw_valid) begin
            if (debias_bypass) begin
                vn_valid = 1'b1;
            end else if (state == HAVE_FIRST && raw_bit != first_bit) begin
                vn_valid = 1'b1;
                vn_bit   = first_bit;
            end
        end
    end

endmodule

// File: rtl/trng_byte_packer.sv
// Debiases raw entropy, packs accepted bits MSB-first into WIDTH-bit words behind a
// one-entry valid/ready register. Define TRNG_HEALTH_EN to add the repetition-count test.
module trng_byte_packer
    import trng_pkg::*;
#(
    parameter int WIDTH     = TRNG_WORD_W,
    parameter int RCT_LIMIT = TRNG_RCT_LIMIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             raw_bit,
    input  logic             raw_valid,
    input  logic             debias_bypass,
    output logic [WIDTH-1:0] byte_out,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             health_fail
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic             vn_bit;
    logic             vn_valid;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic             word_done;
    logic             load;
    logic             health_fail_q;

    trng_von_neumann u_vn (
        .clk           (clk),
        .rst           (rst),
        .raw_bit       (raw_bit),
        .raw_valid     (raw_valid),
        .debias_bypass (debias_bypass),
        .vn_bit        (vn_bit),
        .vn_valid      (vn_valid)
    );

    assign word_done = vn_valid && (bit_cnt == LAST_BIT);
    // A completed word only lands if the output slot is empty or draining right now;
    // otherwise it is thrown away because the raw source cannot be held off.
    assign load = word_done && (!byte_valid || byte_ready) && !health_fail_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (vn_valid) begin
            if (word_done) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else begin
                shreg   <= {shreg[WIDTH-2:0], vn_bit};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_out   <= '0;
            byte_valid <= 1'b0;
        end else if (load) begin
            byte_out   <= {shreg[WIDTH-2:0], vn_bit};
            byte_valid <= 1'b1;
        end else if (health_fail_q || byte_ready) begin
            // Either a plain transfer, or a failed source withdrawing its pending word.
            byte_valid <= 1'b0;
        end
    end

`ifdef TRNG_HEALTH_EN
    localparam int RCT_W = $clog2(RCT_LIMIT + 1);

    logic [RCT_W-1:0] rct_cnt;
    logic [RCT_W-1:0] rct_nxt;
    logic             rct_last;

    always_comb begin
        rct_nxt = RCT_W'(1);
        if (rct_cnt != '0 && raw_bit == rct_last) begin
            rct_nxt = RCT_W'(sat_inc(int'(rct_cnt), RCT_LIMIT));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rct_cnt       <= '0;
            rct_last      <= 1'b0;
            health_fail_q <= 1'b0;
        end else if (raw_valid) begin
            rct_cnt  <= rct_nxt;
            rct_last <= raw_bit;
            if (rct_nxt == RCT_W'(RCT_LIMIT)) begin
                health_fail_q <= 1'b1;
            end
        end
    end
`else
    assign health_fail_q = 1'b0;
`endif

    assign health_fail = health_fail_q;

endmodule

// File: tb/tb_trng_byte_packer.sv
// Scoreboard bench for trng_byte_packer; a behavioural model pushes expected words as
// stimulus is driven and they are popped on each output transfer.
module tb_trng_byte_packer;

    localparam int W   = 8;
    localparam int LIM = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         raw_bit = 1'b0;
    logic         raw_valid = 1'b0;
    logic         debias_bypass = 1'b0;
    logic         byte_ready = 1'b0;
    logic [W-1:0] byte_out;
    logic         byte_valid;
    logic         health_fail;

    always #5 clk = ~clk;

    trng_byte_packer #(.WIDTH(W), .RCT_LIMIT(LIM)) dut (
        .clk           (clk),
        .rst           (rst),
        .raw_bit       (raw_bit),
        .raw_valid     (raw_valid),
        .debias_bypass (debias_bypass),
        .byte_out      (byte_out),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .health_fail   (health_fail)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    bit           m_have;
    bit           m_first;
    int           m_cnt;
    logic [W-1:0] m_sh;
    logic [W-1:0] m_word;
    bit           m_valid;
    bit           m_hf;
    int           m_rct;
    bit           m_last;
    logic [W-1:0] sb[$];

    task automatic model_reset();
        m_have = 0; m_first = 0; m_cnt = 0; m_sh = '0; m_word = '0;
        m_valid = 0; m_hf = 0; m_rct = 0; m_last = 0;
        sb.delete();
    endtask

    // Called at a falling edge: drive inputs, compare outputs, advance the model one clock.
    task automatic step(input bit rb, input bit rv, input bit byp, input bit rdy);
        bit           acc;
        bit           abit;
        bit           xfer;
        bit           load;
        logic [W-1:0] w;
        logic [W-1:0] exp;
        raw_bit = rb; raw_valid = rv; debias_bypass = byp; byte_ready = rdy;

        check("valid", byte_valid, m_valid);
        check("health", health_fail, m_hf);
        if (m_valid && !rdy) check("hold", byte_out, m_word);
        if (byte_valid && rdy) begin
            if (sb.size() == 0) check("sb_underflow", byte_valid, 1'b0);
            else begin
                exp = sb.pop_front();
                check("word", byte_out, exp);
            end
        end

        acc = 0; abit = 0; load = 0; w = '0;
        xfer = m_valid && rdy;
        if (byp) begin
            m_have = 0;
            if (rv) begin acc = 1; abit = rb; end
        end else if (rv) begin
            if (!m_have) begin m_first = rb; m_have = 1; end
            else begin
                m_have = 0;
                if (rb != m_first) begin acc = 1; abit = m_first; end
            end
        end
        if (acc) begin
            if (m_cnt == W - 1) begin
                w = {m_sh[W-2:0], abit};
                if ((!m_valid || rdy) && !m_hf) load = 1;
                m_cnt = 0; m_sh = '0;
            end else begin
                m_sh = {m_sh[W-2:0], abit};
                m_cnt++;
            end
        end
        if (load) begin
            sb.push_back(w); m_word = w; m_valid = 1;
        end else if (m_hf || rdy) begin
            if (m_valid && !xfer) void'(sb.pop_front());
            m_valid = 0;
        end
`ifdef TRNG_HEALTH_EN
        if (rv) begin
            m_rct = (m_rct != 0 && rb == m_last) ? ((m_rct >= LIM) ? LIM : m_rct + 1) : 1;
            m_last = rb;
            if (m_rct == LIM) m_hf = 1;
        end
`endif
        @(negedge clk);
    endtask

    task automatic feed_bypass(input logic [W-1:0] b, input bit rdy);
        for (int i = W - 1; i >= 0; i--) step(b[i], 1, 1, rdy);
    endtask

    task automatic feed_vn(input logic [W-1:0] b, input int nbits, input bit rdy);
        for (int i = W - 1; i >= W - nbits; i--) begin
            step(b[i], 1, 0, rdy);
            step(~b[i], 1, 0, rdy);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_byte_out", byte_out, '0);
        check("rst_valid", byte_valid, 1'b0);
        check("rst_health", health_fail, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [19:0] t2_raw;
        #1;
        do_reset();

        // 1: bypass packing, word visible one cycle after the 8th sample.
        feed_bypass(8'hB2, 1);
        check("t1_valid", byte_valid, 1'b1);
        check("t1_word", byte_out, 8'hB2);
        step(0, 0, 1, 1);
        check("t1_valid_drop", byte_valid, 1'b0);

        // 2: von Neumann pairs with 00/11 discarded.
        t2_raw = 20'b10_01_00_11_10_10_01_01_10_01;
        for (int i = 19; i >= 0; i--) step(t2_raw[i], 1, 0, 1);
        check("t2_valid", byte_valid, 1'b1);
        check("t2_word", byte_out, 8'hB2);
        step(0, 0, 0, 1);

        // 3: held word, second word dropped, then one drain cycle.
        feed_bypass(8'h5A, 0);
        feed_bypass(8'hC3, 0);
        check("t3_hold", byte_out, 8'h5A);
        step(0, 0, 1, 1);
        check("t3_drained", byte_valid, 1'b0);
        feed_bypass(8'h96, 1);
        check("t3_next_word", byte_out, 8'h96);
        step(0, 0, 1, 1);

        // 4: completion coincides with draining the held word.
        feed_bypass(8'h3C, 0);
        for (int i = W - 1; i >= 1; i--) step(1'(8'hA5 >> i), 1, 1, 0);
        step(1'b1, 1, 1, 1);
        check("t4_valid", byte_valid, 1'b1);
        check("t4_word", byte_out, 8'hA5);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);

`ifdef TRNG_HEALTH_EN
        // 5: stuck-at-1 source trips the repetition test and withdraws the pending word.
        for (int i = 0; i < LIM; i++) step(1, 1, 1, 0);
        step(0, 0, 1, 0);
        check("t5_health", health_fail, 1'b1);
        check("t5_valid", byte_valid, 1'b0);
        feed_bypass(8'h69, 1);
        check("t5_no_load", byte_valid, 1'b0);
        do_reset();
        feed_bypass(8'h69, 1);
        check("t5_recover", byte_out, 8'h69);
        step(0, 0, 1, 1);
`endif

        // 6: asynchronous reset mid-word with a word held and the debiaser in HAVE_FIRST.
        feed_bypass(8'hE1, 0);
        feed_vn(8'hA8, 5, 0);
        step(1, 1, 0, 0);
        check("t6_pre_valid", byte_valid, 1'b1);
        #2;
        do_reset();
        feed_vn(8'h4D, 8, 1);
        check("t6_clean", byte_out, 8'h4D);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("t6_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
